// File: rtl/vga_raster_timing.sv
// ============================================================================
// vga_raster_timing : VGA raster counters, sync generation and RGB blanking
//                     aligned to a fixed-latency pixel source. Revision 1.0
// ============================================================================
`default_nettype none

module vga_raster_timing #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   PIX_LAT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_pix_en,
  output logic [15:0] o_x,
  output logic [15:0] o_y,
  output logic        o_active,
  output logic        o_frame_start,
  input  logic [7:0]  i_red,
  input  logic [7:0]  i_green,
  input  logic [7:0]  i_blue,
  output logic        o_hsync,
  output logic        o_vga_vsync,
  output logic        o_vga_de,
  output logic [7:0]  o_vga_r,
  output logic [7:0]  o_vga_g,
  output logic [7:0]  o_vga_b
);

  localparam logic [15:0] C_H_ACT   = 16'(H_ACTIVE);
  localparam logic [15:0] C_V_ACT   = 16'(V_ACTIVE);
  localparam logic [15:0] C_H_LAST  = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] C_V_LAST  = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [15:0] C_HS_FROM = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] C_HS_TO   = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [15:0] C_VS_FROM = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] C_VS_TO   = 16'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [15:0] x_q, x_d, y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (i_pix_en) begin
      if (x_q == C_H_LAST) begin
        x_d = 16'd0;
        y_d = (y_q == C_V_LAST) ? 16'd0 : y_q + 16'd1;
      end else begin
        x_d = x_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= 16'd0;
      y_q <= 16'd0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  logic active, hs_raw, vs_raw;

  assign active        = (x_q < C_H_ACT) && (y_q < C_V_ACT);
  assign hs_raw        = (x_q >= C_HS_FROM) && (x_q <= C_HS_TO);
  assign vs_raw        = (y_q >= C_VS_FROM) && (y_q <= C_VS_TO);
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_active      = active;
  assign o_frame_start = (x_q == 16'd0) && (y_q == 16'd0) && i_pix_en;

  // Pipe stages hold "asserted" flags; polarity is applied only at the pins.
  logic [PIX_LAT-1:0] hs_pipe_q, hs_pipe_d;
  logic [PIX_LAT-1:0] vs_pipe_q, vs_pipe_d;
  logic [PIX_LAT-1:0] de_pipe_q, de_pipe_d;

  generate
    if (PIX_LAT == 1) begin : g_pipe_single
      assign hs_pipe_d = hs_raw;
      assign vs_pipe_d = vs_raw;
      assign de_pipe_d = active;
    end else begin : g_pipe_shift
      assign hs_pipe_d = {hs_pipe_q[PIX_LAT-2:0], hs_raw};
      assign vs_pipe_d = {vs_pipe_q[PIX_LAT-2:0], vs_raw};
      assign de_pipe_d = {de_pipe_q[PIX_LAT-2:0], active};
    end
  endgenerate

  logic       hsync_q, vsync_q, de_q;
  logic [7:0] r_q, g_q, b_q;
  logic       de_last;

  assign de_last = de_pipe_q[PIX_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_pipe_q <= '0;
      vs_pipe_q <= '0;
      de_pipe_q <= '0;
      hsync_q   <= ~HS_POL;
      vsync_q   <= ~VS_POL;
      de_q      <= 1'b0;
      r_q       <= 8'd0;
      g_q       <= 8'd0;
      b_q       <= 8'd0;
    end else if (i_pix_en) begin
      hs_pipe_q <= hs_pipe_d;
      vs_pipe_q <= vs_pipe_d;
      de_pipe_q <= de_pipe_d;
      hsync_q   <= hs_pipe_q[PIX_LAT-1] ? HS_POL : ~HS_POL;
      vsync_q   <= vs_pipe_q[PIX_LAT-1] ? VS_POL : ~VS_POL;
      de_q      <= de_last;
      r_q       <= de_last ? i_red   : 8'd0;
      g_q       <= de_last ? i_green : 8'd0;
      b_q       <= de_last ? i_blue  : 8'd0;
    end
  end

  assign o_hsync     = hsync_q;
  assign o_vga_vsync = vsync_q;
  assign o_vga_de    = de_q;
  assign o_vga_r     = r_q;
  assign o_vga_g     = g_q;
  assign o_vga_b     = b_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_raster_timing.sv
// ============================================================================
// tb_vga_raster_timing : scoreboard bench for vga_raster_timing
//                        (horizontal timing at 640x480 values). Revision 1.0
// ============================================================================
`default_nettype none

module tb_vga_raster_timing;

  localparam int LAT = 2;
  // Vertical timing is shortened so several whole frames fit in a short run:
  // 6 active lines, vsync on lines 8..9, 12 lines per frame.
  localparam int VACT = 6;
  localparam int VTOT = 12;
  localparam int HTOT = 800;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_pix_en;
  logic [15:0] o_x, o_y;
  logic        o_active, o_frame_start;
  logic [7:0]  i_red, i_green, i_blue;
  logic        o_hsync, o_vga_vsync, o_vga_de;
  logic [7:0]  o_vga_r, o_vga_g, o_vga_b;

  always #5 clk = ~clk;

  vga_raster_timing #(
    .V_ACTIVE (6),
    .V_FP     (2),
    .V_SYNC   (2),
    .V_BP     (2),
    .PIX_LAT  (LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_pix_en      (i_pix_en),
    .o_x           (o_x),
    .o_y           (o_y),
    .o_active      (o_active),
    .o_frame_start (o_frame_start),
    .i_red         (i_red),
    .i_green       (i_green),
    .i_blue        (i_blue),
    .o_hsync       (o_hsync),
    .o_vga_vsync   (o_vga_vsync),
    .o_vga_de      (o_vga_de),
    .o_vga_r       (o_vga_r),
    .o_vga_g       (o_vga_g),
    .o_vga_b       (o_vga_b)
  );

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } exp_t;

  localparam exp_t C_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, r: 8'd0, g: 8'd0, b: 8'd0};

  exp_t       q[$];
  exp_t       last_exp;
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         mx, my;
  logic       mode;
  logic       quarter;
  logic       wrap_seen;
  int         wrap_cyc;
  logic [7:0] dp_r [LAT];
  logic [7:0] dp_g [LAT];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endfunction

  function automatic exp_t pix_exp(input int x, input int y, input logic [7:0] r, input logic [7:0] g);
    exp_t e;
    e.hs = (x >= 656 && x <= 751) ? 1'b0 : 1'b1;
    e.vs = (y == 8 || y == 9) ? 1'b0 : 1'b1;
    e.de = (x < 640) && (y < VACT);
    e.r  = e.de ? r : 8'd0;
    e.g  = e.de ? g : 8'd0;
    e.b  = e.de ? 8'h55 : 8'd0;
    return e;
  endfunction

  // Monitor: every enabled edge retires one scoreboard entry; disabled edges must hold.
  logic rst_s, en_s;
  exp_t got_e, mon_e;
  initial begin
    last_exp = C_IDLE;
    forever begin
      @(posedge clk);
      rst_s = rst;
      en_s  = i_pix_en;
      #1;
      got_e = '{hs: o_hsync, vs: o_vga_vsync, de: o_vga_de, r: o_vga_r, g: o_vga_g, b: o_vga_b};
      if (rst_s) begin
        chk("vga_reset", 64'(got_e), 64'(C_IDLE));
        last_exp = C_IDLE;
      end else if (en_s) begin
        if (q.size() == 0) begin
          chk("queue_underflow", 64'(q.size()), 64'd1);
        end else begin
          mon_e = q.pop_front();
          chk("vga_pixel", 64'(got_e), 64'(mon_e));
          last_exp = mon_e;
        end
      end else begin
        chk("vga_hold", 64'(got_e), 64'(last_exp));
      end
    end
  end

  task automatic do_reset(input int n, input logic en);
    @(negedge clk);
    rst      = 1'b1;
    i_pix_en = en;
    q.delete();
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("coord_reset", {o_x, o_y, o_active}, {16'd0, 16'd0, 1'b1});
    end
    rst = 1'b0;
    mx  = 0;
    my  = 0;
    for (int i = 0; i < LAT; i++) q.push_back(C_IDLE);
  endtask

  task automatic tick(input logic en);
    logic [7:0] cr, cg;
    logic       act, fs;
    @(negedge clk);
    i_pix_en = en;
    #1;
    act = (mx < 640) && (my < VACT);
    fs  = (mx == 0) && (my == 0) && en;
    chk("coord", {o_x, o_y, o_active, o_frame_start}, {16'(mx), 16'(my), act, fs});
    cr = mode ? 8'(mx) : 8'hAA;
    cg = 8'(my);
    if (en) begin
      q.push_back(pix_exp(mx, my, cr, cg));
      if (quarter && mx == 0) begin
        if (wrap_seen) chk("line_period", 64'(cyc - wrap_cyc), 64'd3200);
        wrap_seen = 1'b1;
        wrap_cyc  = cyc;
      end
    end
    @(posedge clk);
    #1;
    if (en) begin
      for (int i = LAT - 1; i > 0; i--) begin
        dp_r[i] = dp_r[i-1];
        dp_g[i] = dp_g[i-1];
      end
      dp_r[0] = cr;
      dp_g[0] = cg;
      i_red   = dp_r[LAT-1];
      i_green = dp_g[LAT-1];
      if (mx == HTOT - 1) begin
        mx = 0;
        my = (my == VTOT - 1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    i_pix_en  = 1'b1;
    i_red     = 8'h00;
    i_green   = 8'h00;
    i_blue    = 8'h55;
    mode      = 1'b0;
    quarter   = 1'b0;
    wrap_seen = 1'b0;
    wrap_cyc  = 0;
    mx        = 0;
    my        = 0;
    for (int i = 0; i < LAT; i++) begin
      dp_r[i] = 8'h00;
      dp_g[i] = 8'h00;
    end

    do_reset(3, 1'b1);

    // One full frame with constant red, then column-index red.
    repeat (HTOT * VTOT) tick(1'b1);
    mode = 1'b1;
    repeat (HTOT * VTOT + 10) tick(1'b1);

    // 1-in-4 pixel enable for three lines.
    quarter = 1'b1;
    repeat (3 * HTOT) begin
      tick(1'b1);
      repeat (3) tick(1'b0);
    end
    quarter = 1'b0;

    // Walk to x=700, y=2 (inside the hsync pulse), then reset there.
    for (int n = 0; n < HTOT * VTOT && !(mx == 700 && my == 2); n++) tick(1'b1);
    chk("reach_700_2", {16'(mx), 16'(my)}, {16'd700, 16'd2});
    do_reset(1, 1'b1);
    repeat (2 * HTOT + 100) tick(1'b1);

    // Reset with the pixel enable low must still take effect.
    do_reset(2, 1'b0);
    repeat (HTOT + 50) tick(1'b1);

    chk("queue_depth", 64'(q.size()), 64'(LAT));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
